disp_writer: RTL

DISP_WRITER -- requirements
Module: disp_writer

---
 rtl/disp_pkg.sv | 18 +
 rtl/dd_adj3.sv | 17 +
 rtl/disp_writer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the decimal display writer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package disp_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam int         VAL_W      = 27;
    localparam int         MAX_VAL    = 99_999_999;
    localparam logic [3:0] NO_WRITE   = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dd_adj3.sv
// Double-dabble nibble correction: add 3 when the BCD nibble is 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module dd_adj3 (
    input  logic [3:0] nib,
    output logic [3:0] adj
);

    // Correct the nibble so the following left shift carries into the next decade.
    always_comb begin
        adj = nib;
        if (nib >= 4'd5) begin
            adj = nib + 4'd3;
        end
    end

endmodule

// File: rtl/disp_writer.sv
// Converts a binary value to BCD and writes each digit to a display controller.
// Latency: first write VAL_W+1 cycles after the accepted start, done NUM_DIGITS cycles later.
// Backpressure: none; start is only sampled in IDLE, otherwise dropped.
module disp_writer #(
    parameter int NUM_DIGITS = disp_pkg::NUM_DIGITS,
    parameter int VAL_W      = disp_pkg::VAL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       dig,
    output logic [3:0]       pos
);

    import disp_pkg::*;

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);

    state_t           state_q, state_d;
    logic [VAL_W-1:0] val_q, val_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj, bcd_shift;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, done_d, err_d;
    logic [3:0]       dig_d, pos_d, dig_sel;

    // One add-3 corrector per decade.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
        dd_adj3 u_adj (
            .nib (bcd_q[4*i +: 4]),
            .adj (bcd_adj[4*i +: 4])
        );
    end

    // One double-dabble step: shift the corrected BCD left, pulling in the value MSB.
    assign bcd_shift = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, val_q[VAL_W-1]};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dig_d   = NO_WRITE;
        pos_d   = NO_WRITE;
        dig_sel = NO_WRITE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                dig_sel = bcd_q[4*i +: 4];
            end
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (value > VAL_W'(MAX_VAL)) begin
                        err_d = 1'b1;
                    end else begin
                        val_d   = value;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                bcd_d  = bcd_shift;
                val_d  = val_q << 1;
                busy_d = 1'b1;
                // The last iteration also presents digit 0, so writes start on WRITE entry.
                if (cnt_q == CNT_W'(VAL_W - 1)) begin
                    state_d = WRITE;
                    cnt_d   = CNT_W'(1);
                    dig_d   = bcd_shift[3:0];
                    pos_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                // cnt_q is the index of the digit to present next.
                if (cnt_q == CNT_W'(NUM_DIGITS)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    dig_d  = dig_sel;
                    pos_d  = 4'(cnt_q);
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            val_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            dig   <= NO_WRITE;
            pos   <= NO_WRITE;
        end else begin
            val_q <= val_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            busy  <= busy_d;
            done  <= done_d;
            err   <= err_d;
            dig   <= dig_d;
            pos   <= pos_d;
        end
    end

endmodule
